rv32i_alu_decoder: RTL and testbench

Decode stage for RV32I register-register (OP) and register-immediate (OP_IMM) ALU instructions; the inverse of the instruction-generation tasks used to build IMEM.txt.
- Accepts 32-bit instruction words over a valid/ready handshake.
- Splits each word into register indices, a sign-extended immediate, an ALU opcode and control flags, and flags illegal encodings.
- Sits between instruction fetch and the register-file/ALU stage; fully registered, with a one-entry skid buffer so upstream ready is a flop.

---
 rtl/rv32i_alu_decoder.sv | 157 +++++++++++++++
 tb/tb_rv32i_alu_decoder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_alu_decoder.sv
// rv32i_alu_decoder: registered RV32I OP/OP_IMM decode stage with a one-entry skid buffer.
// Define DECODE_STATS_EN to enable the transfer/illegal statistics counters.
module rv32i_alu_decoder #(
    parameter int XLEN     = 32,
    parameter int ALU_OP_W = 4
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [31:0]         i_instr,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic                i_flush,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [4:0]          o_rd,
    output logic [4:0]          o_rs1,
    output logic [4:0]          o_rs2,
    output logic [XLEN-1:0]     o_imm,
    output logic [ALU_OP_W-1:0] o_alu_op,
    output logic                o_use_imm,
    output logic                o_reg_write,
    output logic                o_illegal,
    output logic [31:0]         o_decoded_cnt,
    output logic [31:0]         o_illegal_cnt
);
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
    typedef struct packed {
        logic [4:0]          rd;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [XLEN-1:0]     imm;
        logic [ALU_OP_W-1:0] alu_op;
        logic                use_imm;
        logic                reg_write;
        logic                illegal;
    } dec_t;

    localparam logic [6:0] OPC_OP  = 7'b0110011;
    localparam logic [6:0] OPC_IMM = 7'b0010011;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    state_t              state;
    dec_t                dec, out_q, skid_q;
    logic [6:0]          opc, f7;
    logic [2:0]          f3;
    logic                alt, is_op, is_imm, is_shift, legal, acc, drn;
    logic [ALU_OP_W-1:0] base_op;

    assign acc = i_valid && o_ready;
    assign drn = o_valid && i_ready;

    always_comb begin
        opc      = i_instr[6:0];
        f3       = i_instr[14:12];
        f7       = i_instr[31:25];
        alt      = f7 == F7_ALT;
        is_op    = opc == OPC_OP;
        is_imm   = opc == OPC_IMM;
        is_shift = f3 == 3'd1 || f3 == 3'd5;
        legal    = is_op  ? (f7 == 7'd0 || (alt && (f3 == 3'd0 || f3 == 3'd5))) :
                   is_imm ? (f3 == 3'd1 ? f7 == 7'd0 : f3 == 3'd5 ? (f7 == 7'd0 || alt) : 1'b1) :
                   1'b0;
        case (f3)
            3'd0:    base_op = ALU_OP_W'(0);
            3'd1:    base_op = ALU_OP_W'(2);
            3'd2:    base_op = ALU_OP_W'(3);
            3'd3:    base_op = ALU_OP_W'(4);
            3'd4:    base_op = ALU_OP_W'(5);
            3'd5:    base_op = ALU_OP_W'(6);
            3'd6:    base_op = ALU_OP_W'(8);
            default: base_op = ALU_OP_W'(9);
        endcase
        dec           = '0;
        dec.rd        = i_instr[11:7];
        dec.rs1       = i_instr[19:15];
        dec.rs2       = i_instr[24:20];
        dec.illegal   = !legal;
        dec.reg_write = legal && i_instr[11:7] != 5'd0;
        dec.use_imm   = legal && is_imm;
        // SUB and SRA sit one code above ADD and SRL; ADDI never selects SUB
        dec.alu_op    = !legal ? ALU_OP_W'(0) :
                        (alt && (f3 == 3'd0 ? is_op : f3 == 3'd5)) ? base_op + ALU_OP_W'(1) : base_op;
        dec.imm       = !(legal && is_imm) ? '0 :
                        is_shift ? XLEN'(i_instr[24:20]) : {{(XLEN-12){i_instr[31]}}, i_instr[31:20]};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= EMPTY;
            o_valid <= 1'b0;
            o_ready <= 1'b1;
            out_q   <= '0;
            skid_q  <= '0;
        end else if (i_flush) begin
            state   <= EMPTY;
            o_valid <= 1'b0;
            o_ready <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (acc) begin
                        out_q   <= dec;
                        state   <= ONE;
                        o_valid <= 1'b1;
                    end
                end
                ONE: begin
                    if (acc && drn) begin
                        out_q <= dec;
                    end else if (acc) begin
                        skid_q  <= dec;
                        state   <= FULL;
                        o_ready <= 1'b0;
                    end else if (drn) begin
                        state   <= EMPTY;
                        o_valid <= 1'b0;
                    end
                end
                FULL: begin
                    if (drn) begin
                        out_q   <= skid_q;
                        state   <= ONE;
                        o_ready <= 1'b1;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    assign o_rd        = out_q.rd;
    assign o_rs1       = out_q.rs1;
    assign o_rs2       = out_q.rs2;
    assign o_imm       = out_q.imm;
    assign o_alu_op    = out_q.alu_op;
    assign o_use_imm   = out_q.use_imm;
    assign o_reg_write = out_q.reg_write;
    assign o_illegal   = out_q.illegal;

`ifdef DECODE_STATS_EN
    logic [31:0] dec_cnt, ill_cnt;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            dec_cnt <= '0;
            ill_cnt <= '0;
        end else if (drn) begin
            dec_cnt <= dec_cnt + 32'd1;
            ill_cnt <= ill_cnt + {31'd0, out_q.illegal};
        end
    end
    assign o_decoded_cnt = dec_cnt;
    assign o_illegal_cnt = ill_cnt;
`else
    assign o_decoded_cnt = '0;
    assign o_illegal_cnt = '0;
`endif
endmodule

// File: tb/tb_rv32i_alu_decoder.sv
// tb_rv32i_alu_decoder: directed and randomized checks of rv32i_alu_decoder against a mnemonic-level model.
module tb_rv32i_alu_decoder;
    logic        i_clk, i_rst_n, i_valid, i_ready, i_flush;
    logic [31:0] i_instr;
    logic        o_ready, o_valid, o_use_imm, o_reg_write, o_illegal;
    logic [4:0]  o_rd, o_rs1, o_rs2;
    logic [31:0] o_imm, o_decoded_cnt, o_illegal_cnt;
    logic [3:0]  o_alu_op;

    rv32i_alu_decoder dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_instr(i_instr), .i_valid(i_valid),
        .o_ready(o_ready), .i_flush(i_flush), .o_valid(o_valid), .i_ready(i_ready),
        .o_rd(o_rd), .o_rs1(o_rs1), .o_rs2(o_rs2), .o_imm(o_imm), .o_alu_op(o_alu_op),
        .o_use_imm(o_use_imm), .o_reg_write(o_reg_write), .o_illegal(o_illegal),
        .o_decoded_cnt(o_decoded_cnt), .o_illegal_cnt(o_illegal_cnt)
    );

`ifdef DECODE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct packed {
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
        logic [3:0]  alu;
        logic        use_imm, reg_write, illegal;
    } exp_t;

    exp_t        q[$];
    logic [31:0] m_dec, m_ill;
    int          n_checks = 0, n_fail = 0;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Mnemonic table: each legal (opcode, funct3, funct7) combination listed explicitly
    function automatic exp_t ref_dec(input logic [31:0] w);
        exp_t       e;
        int         alu, s;
        logic [9:0] key;
        logic [31:0] imm;
        e   = '0;
        alu = -1;
        imm = 32'd0;
        key = {w[31:25], w[14:12]};
        e.rd  = w[11:7];
        e.rs1 = w[19:15];
        e.rs2 = w[24:20];
        if (w[6:0] == 7'h33) begin
            case (key)
                {7'h00, 3'd0}: alu = 0;
                {7'h20, 3'd0}: alu = 1;
                {7'h00, 3'd1}: alu = 2;
                {7'h00, 3'd2}: alu = 3;
                {7'h00, 3'd3}: alu = 4;
                {7'h00, 3'd4}: alu = 5;
                {7'h00, 3'd5}: alu = 6;
                {7'h20, 3'd5}: alu = 7;
                {7'h00, 3'd6}: alu = 8;
                {7'h00, 3'd7}: alu = 9;
                default:       alu = -1;
            endcase
        end else if (w[6:0] == 7'h13) begin
            e.use_imm = 1'b1;
            s = int'(w[31:20]);
            if (s >= 2048) s -= 4096;
            imm = s;
            case (w[14:12])
                3'd0: alu = 0;
                3'd2: alu = 3;
                3'd3: alu = 4;
                3'd4: alu = 5;
                3'd6: alu = 8;
                3'd7: alu = 9;
                3'd1: begin alu = (w[31:25] == 7'h00) ? 2 : -1; imm = 32'(w[24:20]); end
                default: begin
                    alu = (w[31:25] == 7'h00) ? 6 : (w[31:25] == 7'h20) ? 7 : -1;
                    imm = 32'(w[24:20]);
                end
            endcase
        end
        e.illegal   = alu < 0;
        e.alu       = e.illegal ? 4'd0 : 4'(alu);
        e.imm       = imm;
        e.reg_write = !e.illegal && e.rd != 5'd0;
        return e;
    endfunction

    task automatic scoreboard();
        exp_t e;
        check("valid", 32'(o_valid), 32'(q.size() > 0));
        check("ready", 32'(o_ready), 32'(q.size() < 2));
        if (q.size() > 0) begin
            e = q[0];
            check("rd", 32'(o_rd), 32'(e.rd));
            check("rs1", 32'(o_rs1), 32'(e.rs1));
            check("rs2", 32'(o_rs2), 32'(e.rs2));
            check("alu_op", 32'(o_alu_op), 32'(e.alu));
            check("reg_write", 32'(o_reg_write), 32'(e.reg_write));
            check("illegal", 32'(o_illegal), 32'(e.illegal));
            if (!e.illegal) begin
                check("imm", o_imm, e.imm);
                check("use_imm", 32'(o_use_imm), 32'(e.use_imm));
            end
        end
        check("decoded_cnt", o_decoded_cnt, STATS ? m_dec : 32'd0);
        check("illegal_cnt", o_illegal_cnt, STATS ? m_ill : 32'd0);
    endtask

    // Drive one cycle from a negedge, advance the model, then check at the next negedge
    task automatic cycle(input logic v, input logic [31:0] w, input logic rdy, input logic fl);
        logic acc, drn;
        i_valid = v;
        i_instr = w;
        i_ready = rdy;
        i_flush = fl;
        acc = v && q.size() < 2;
        drn = q.size() > 0 && rdy;
        if (drn) begin
            m_dec++;
            if (q[0].illegal) m_ill++;
        end
        if (fl) q.delete();
        else begin
            if (drn) void'(q.pop_front());
            if (acc) q.push_back(ref_dec(w));
        end
        @(posedge i_clk);
        @(negedge i_clk);
        scoreboard();
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        int          k;
        w = $urandom;
        k = $urandom_range(0, 9);
        w[6:0] = (k < 4) ? 7'h33 : (k < 8) ? 7'h13 : w[6:0];
        k = $urandom_range(0, 9);
        if (k < 5) w[31:25] = 7'h00;
        else if (k < 8) w[31:25] = 7'h20;
        return w;
    endfunction

    initial begin
        logic v, rdy, fl;
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_flush = 1'b0;
        i_instr = 32'd0;
        m_dec   = 32'd0;
        m_ill   = 32'd0;
        repeat (2) @(negedge i_clk);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_ready", 32'(o_ready), 32'd1);
        check("rst_rd", 32'(o_rd), 32'd0);
        check("rst_imm", o_imm, 32'd0);
        check("rst_dec_cnt", o_decoded_cnt, 32'd0);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        cycle(1'b1, 32'h002081B3, 1'b1, 1'b0);
        check("add_rd", 32'(o_rd), 32'd3);
        check("add_rs1", 32'(o_rs1), 32'd1);
        check("add_rs2", 32'(o_rs2), 32'd2);
        check("add_alu", 32'(o_alu_op), 32'd0);
        check("add_use_imm", 32'(o_use_imm), 32'd0);
        check("add_reg_write", 32'(o_reg_write), 32'd1);
        check("add_illegal", 32'(o_illegal), 32'd0);
        cycle(1'b1, 32'hFFF00293, 1'b1, 1'b0);
        check("addi_imm", o_imm, 32'hFFFFFFFF);
        check("addi_alu", 32'(o_alu_op), 32'd0);
        check("addi_use_imm", 32'(o_use_imm), 32'd1);
        check("addi_rd", 32'(o_rd), 32'd5);
        cycle(1'b1, 32'h4043D313, 1'b1, 1'b0);
        check("srai_alu", 32'(o_alu_op), 32'd7);
        check("srai_imm", o_imm, 32'd4);
        cycle(1'b1, 32'h402081B3, 1'b1, 1'b0);
        check("sub_alu", 32'(o_alu_op), 32'd1);
        check("sub_use_imm", 32'(o_use_imm), 32'd0);
        cycle(1'b1, 32'h0000007F, 1'b1, 1'b0);
        check("bad_opc_illegal", 32'(o_illegal), 32'd1);
        check("bad_opc_reg_write", 32'(o_reg_write), 32'd0);
        cycle(1'b1, 32'h40209093, 1'b1, 1'b0);
        check("bad_slli_illegal", 32'(o_illegal), 32'd1);
        check("bad_slli_reg_write", 32'(o_reg_write), 32'd0);
        check("bad_slli_alu", 32'(o_alu_op), 32'd0);
        cycle(1'b0, 32'd0, 1'b1, 1'b0);
        check("ill_cnt_two", o_illegal_cnt, STATS ? 32'd2 : 32'd0);

        // Backpressure: ADDI x10/x11/x12 back to back with i_ready low
        cycle(1'b1, 32'h00100513, 1'b0, 1'b0);
        check("bp_ready1", 32'(o_ready), 32'd1);
        cycle(1'b1, 32'h00200593, 1'b0, 1'b0);
        check("bp_ready2", 32'(o_ready), 32'd0);
        cycle(1'b1, 32'h00300613, 1'b0, 1'b0);
        check("bp_hold_rd", 32'(o_rd), 32'd10);
        cycle(1'b1, 32'h00300613, 1'b1, 1'b0);
        check("bp_second_rd", 32'(o_rd), 32'd11);
        cycle(1'b1, 32'h00300613, 1'b1, 1'b0);
        check("bp_third_rd", 32'(o_rd), 32'd12);
        cycle(1'b0, 32'd0, 1'b1, 1'b0);
        check("bp_drained", 32'(o_valid), 32'd0);

        // Flush from FULL with a concurrent word, then from ONE with a concurrent accept
        cycle(1'b1, 32'h00100693, 1'b0, 1'b0);
        cycle(1'b1, 32'h00200713, 1'b0, 1'b0);
        cycle(1'b1, 32'h00300793, 1'b0, 1'b1);
        check("flush_valid", 32'(o_valid), 32'd0);
        check("flush_ready", 32'(o_ready), 32'd1);
        cycle(1'b1, 32'h00400813, 1'b0, 1'b0);
        cycle(1'b1, 32'h00500893, 1'b0, 1'b1);
        check("flush_one_valid", 32'(o_valid), 32'd0);
        repeat (3) cycle(1'b0, 32'd0, 1'b1, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            v   = $urandom_range(0, 3) != 0;
            rdy = $urandom_range(0, 2) != 0;
            fl  = $urandom_range(0, 39) == 0;
            if (fl) rdy = 1'b0;
            cycle(v, rand_word(), rdy, fl);
        end

        // Asynchronous reset between clock edges while the pipeline is full
        cycle(1'b1, 32'h00100913, 1'b0, 1'b0);
        cycle(1'b1, 32'h00200993, 1'b0, 1'b0);
        #2 i_rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(o_valid), 32'd0);
        check("async_rst_ready", 32'(o_ready), 32'd1);
        check("async_rst_dec_cnt", o_decoded_cnt, 32'd0);
        check("async_rst_rd", 32'(o_rd), 32'd0);
        q.delete();
        m_dec = 32'd0;
        m_ill = 32'd0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        cycle(1'b1, 32'h002081B3, 1'b1, 1'b0);
        cycle(1'b0, 32'd0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
